vgpr_wr_port_arbiter: RTL

VGPR_WR_PORT_ARBITER -- requirements
Module: vgpr_wr_port_arbiter

---
 rtl/vgpr_wr_port_arbiter_pkg.sv | 19 +
 rtl/vgpr_wr_port_arbiter_rr_priority_encoder.sv | 35 +++
 rtl/vgpr_wr_port_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/vgpr_wr_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vgpr_wr_port_arbiter_pkg
// Description : Shared sizes and state encodings for the VGPR write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vgpr_wr_port_arbiter_pkg;

    localparam int VGPR_NUM_PORTS = 8;
    localparam int VGPR_MAX_BURST = 4;
    localparam int VGPR_SEL_W     = 16;
    localparam int VGPR_PTR_W     = $clog2(VGPR_NUM_PORTS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage : vgpr_wr_port_arbiter_pkg
`default_nettype wire

// File: rtl/vgpr_wr_port_arbiter_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_encoder
// Description : First set request at or after a rotating start position.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_encoder
    import vgpr_wr_port_arbiter_pkg::*;
(
    input  logic [VGPR_NUM_PORTS-1:0] req,
    input  logic [VGPR_PTR_W-1:0]     start,
    output logic [VGPR_NUM_PORTS-1:0] onehot,
    output logic [VGPR_PTR_W-1:0]     index,
    output logic                      valid
);

    logic [VGPR_PTR_W-1:0] w_pos;

    // Walk from the farthest position back to start so the nearest hit wins.
    always_comb begin
        w_pos  = start;
        index  = '0;
        valid  = 1'b0;
        for (int k = VGPR_NUM_PORTS - 1; k >= 0; k--) begin
            w_pos = start + VGPR_PTR_W'(k);
            if (req[w_pos]) begin
                valid = 1'b1;
                index = w_pos;
            end
        end
        onehot = valid ? (VGPR_NUM_PORTS'(1) << index) : '0;
    end

endmodule : rr_priority_encoder
`default_nettype wire

// File: rtl/vgpr_wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vgpr_wr_port_arbiter
// Description : Round-robin VGPR write-port arbiter with bounded lock bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module vgpr_wr_port_arbiter
    import vgpr_wr_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = VGPR_NUM_PORTS,
    parameter int MAX_BURST = VGPR_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  lock,
    input  logic                  vgpr_busy,
    output logic [VGPR_SEL_W-1:0] wr_port_select,
    output logic [NUM_PORTS-1:0]  grant,
    output logic                  arb_locked
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [1:0]            r_state;
    logic [VGPR_PTR_W-1:0] r_rr_ptr;
    logic [VGPR_PTR_W-1:0] r_owner;
    logic [CNT_W-1:0]      r_lock_cnt;
    logic [NUM_PORTS-1:0]  r_grant;

    logic [NUM_PORTS-1:0]  w_enc_onehot;
    logic [VGPR_PTR_W-1:0] w_enc_index;
    logic                  w_enc_valid;

    logic                  w_owner_cont;
    logic                  w_win_valid;
    logic [VGPR_PTR_W-1:0] w_win_idx;
    logic [NUM_PORTS-1:0]  w_win_onehot;
    logic [CNT_W-1:0]      w_next_cnt;
    logic                  w_next_locked;
    logic [1:0]            w_next_state;

    // The pointer already sits at owner+1 during a burst, so a released
    // burst re-arbitrates from the right place without special casing.
    rr_priority_encoder u_rr_priority_encoder (
        .req    (req),
        .start  (r_rr_ptr),
        .onehot (w_enc_onehot),
        .index  (w_enc_index),
        .valid  (w_enc_valid)
    );

    always_comb begin
        w_owner_cont = (r_state == ST_LOCKED) && req[r_owner] && lock[r_owner];
        w_win_valid  = w_enc_valid;
        w_win_idx    = w_enc_index;
        w_win_onehot = w_enc_onehot;
        w_next_cnt   = (w_enc_valid && lock[w_enc_index]) ? CNT_W'(1) : '0;
        if (w_owner_cont) begin
            w_win_valid  = 1'b1;
            w_win_idx    = r_owner;
            w_win_onehot = NUM_PORTS'(1) << r_owner;
            w_next_cnt   = r_lock_cnt + CNT_W'(1);
        end
        // Hitting the burst limit on this grant releases the owner immediately.
        w_next_locked = w_win_valid && lock[w_win_idx] && (w_next_cnt < CNT_W'(MAX_BURST));
        if (!w_win_valid) begin
            w_next_state = ST_IDLE;
        end else if (w_next_locked) begin
            w_next_state = ST_LOCKED;
        end else begin
            w_next_state = ST_GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_grant    <= '0;
        end else if (vgpr_busy) begin
            r_grant <= '0;
        end else begin
            r_state    <= w_next_state;
            r_lock_cnt <= w_next_cnt;
            r_grant    <= w_win_valid ? w_win_onehot : '0;
            if (w_win_valid) begin
                r_owner  <= w_win_idx;
                r_rr_ptr <= w_win_idx + VGPR_PTR_W'(1);
            end
        end
    end

    assign wr_port_select = {{(VGPR_SEL_W - NUM_PORTS){1'b0}}, r_grant};
    assign grant          = r_grant;
    assign arb_locked     = (r_state == ST_LOCKED);

endmodule : vgpr_wr_port_arbiter
`default_nettype wire
